// File: rtl/mem_bus_arbiter_if.sv
// rtl/mem_bus_arbiter_if.sv - requester and external bus signals shared by the arbiter and its peers
interface mem_bus_arbiter_if;
    logic        I_req;
    logic [15:0] I_addr;
    logic [7:0]  I_data;
    logic        I_wait;

    logic [15:0] D_addr;
    logic [7:0]  D_wdata;
    logic        D_MREQ;
    logic        D_IORQ;
    logic        D_RD;
    logic        D_WR;
    logic [7:0]  D_rdata;
    logic        D_wait;

    logic [15:0] B_addr;
    logic [7:0]  B_wdata;
    logic [7:0]  B_rdata;
    logic        B_MREQ;
    logic        B_IORQ;
    logic        B_RD;
    logic        B_WR;
    logic        B_ready;

    logic        grant_I;
    logic        grant_D;
    logic        err;

    modport master (
        output I_req, I_addr, D_addr, D_wdata, D_MREQ, D_IORQ, D_RD, D_WR, B_rdata, B_ready,
        input  I_data, I_wait, D_rdata, D_wait, B_addr, B_wdata, B_MREQ, B_IORQ, B_RD, B_WR,
               grant_I, grant_D, err
    );

    modport slave (
        input  I_req, I_addr, D_addr, D_wdata, D_MREQ, D_IORQ, D_RD, D_WR, B_rdata, B_ready,
        output I_data, I_wait, D_rdata, D_wait, B_addr, B_wdata, B_MREQ, B_IORQ, B_RD, B_WR,
               grant_I, grant_D, err
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-requester bus arbiter with D-port priority, fetch anti-starvation and bus watchdog
module mem_bus_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic              CLK,
    input  logic              RST,
    mem_bus_arbiter_if.slave  bus
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [SW-1:0] STARVE_SAT = SW'(STARVE_MAX);
    localparam logic [WW-1:0] WD_LAST    = WW'(TIMEOUT - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_D_XFER, ST_I_XFER} state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic [SW-1:0] r_starve;
    logic [WW-1:0] r_wdog;
    logic          r_err;
    logic [15:0]   r_b_addr;
    logic [7:0]    r_b_wdata;
    logic          r_b_mreq, r_b_iorq, r_b_rd, r_b_wr;

    logic w_d_req, w_d_valid, w_d_conflict;
    logic w_in_xfer, w_wd_expire, w_complete, w_timeout;
    logic w_grant_d, w_grant_i;
    logic [7:0] w_rd_val;

    always_comb begin
        w_d_req      = bus.D_MREQ | bus.D_IORQ;
        w_d_valid    = (bus.D_MREQ ^ bus.D_IORQ) & (bus.D_RD ^ bus.D_WR);
        w_d_conflict = w_d_req & ((bus.D_MREQ & bus.D_IORQ) | (bus.D_RD & bus.D_WR));
        w_in_xfer    = (r_state != ST_IDLE);
        w_wd_expire  = w_in_xfer & (r_wdog == WD_LAST);
        // A dead slave is treated as a completion so the requester never hangs
        w_complete   = w_in_xfer & (bus.B_ready | w_wd_expire);
        w_timeout    = w_wd_expire & ~bus.B_ready;
        w_rd_val     = w_timeout ? 8'hFF : (r_b_rd ? bus.B_rdata : 8'h00);
    end

    always_comb begin
        w_next_state = r_state;
        w_grant_d    = 1'b0;
        w_grant_i    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_d_valid && bus.I_req) begin
                    if (r_starve >= STARVE_SAT) w_grant_i = 1'b1;
                    else                        w_grant_d = 1'b1;
                end else if (w_d_valid) begin
                    w_grant_d = 1'b1;
                end else if (bus.I_req) begin
                    w_grant_i = 1'b1;
                end
                if (w_grant_d)      w_next_state = ST_D_XFER;
                else if (w_grant_i) w_next_state = ST_I_XFER;
            end
            ST_D_XFER, ST_I_XFER: begin
                if (w_complete) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) r_state <= ST_IDLE;
        else     r_state <= w_next_state;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_b_addr  <= 16'h0000;
            r_b_wdata <= 8'h00;
            r_b_mreq  <= 1'b0;
            r_b_iorq  <= 1'b0;
            r_b_rd    <= 1'b0;
            r_b_wr    <= 1'b0;
        end else if (w_grant_d) begin
            r_b_addr  <= bus.D_addr;
            r_b_wdata <= bus.D_wdata;
            r_b_mreq  <= bus.D_MREQ;
            r_b_iorq  <= bus.D_IORQ;
            r_b_rd    <= bus.D_RD;
            r_b_wr    <= bus.D_WR;
        end else if (w_grant_i) begin
            r_b_addr  <= bus.I_addr;
            r_b_wdata <= 8'h00;
            r_b_mreq  <= 1'b1;
            r_b_iorq  <= 1'b0;
            r_b_rd    <= 1'b1;
            r_b_wr    <= 1'b0;
        end else if (w_complete) begin
            r_b_addr  <= 16'h0000;
            r_b_wdata <= 8'h00;
            r_b_mreq  <= 1'b0;
            r_b_iorq  <= 1'b0;
            r_b_rd    <= 1'b0;
            r_b_wr    <= 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_starve <= '0;
            r_wdog   <= '0;
            r_err    <= 1'b0;
        end else begin
            r_err <= r_err | w_d_conflict | w_timeout;
            if (w_grant_i)
                r_starve <= '0;
            else if (w_grant_d && bus.I_req && r_starve < STARVE_SAT)
                r_starve <= r_starve + 1'b1;
            if (w_in_xfer && !w_complete && r_wdog != WD_LAST)
                r_wdog <= r_wdog + 1'b1;
            else if (!w_in_xfer || w_complete)
                r_wdog <= '0;
        end
    end

    assign bus.B_addr  = r_b_addr;
    assign bus.B_wdata = r_b_wdata;
    assign bus.B_MREQ  = r_b_mreq;
    assign bus.B_IORQ  = r_b_iorq;
    assign bus.B_RD    = r_b_rd;
    assign bus.B_WR    = r_b_wr;
    assign bus.grant_D = (r_state == ST_D_XFER);
    assign bus.grant_I = (r_state == ST_I_XFER);
    assign bus.err     = r_err;
    assign bus.D_rdata = ((r_state == ST_D_XFER) && w_complete) ? w_rd_val : 8'h00;
    assign bus.I_data  = ((r_state == ST_I_XFER) && w_complete) ? w_rd_val : 8'h00;
    assign bus.D_wait  = w_d_req & ~((r_state == ST_D_XFER) & w_complete);
    assign bus.I_wait  = bus.I_req & ~((r_state == ST_I_XFER) & w_complete);
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed and randomized checks of mem_bus_arbiter against a transaction-level model
module tb_mem_bus_arbiter;
    localparam int TB_STARVE  = 4;
    localparam int TB_TIMEOUT = 64;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    mem_bus_arbiter_if bus();

    mem_bus_arbiter #(.STARVE_MAX(TB_STARVE), .TIMEOUT(TB_TIMEOUT)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    // transaction-level reference: who owns the bus, what it captured, how long it has waited
    int          m_owner;
    int          m_age;
    int          m_starve;
    bit          m_err;
    logic [15:0] m_addr;
    logic [7:0]  m_wdata;
    bit          m_mreq, m_iorq, m_rd, m_wr;

    task automatic idle_inputs();
        bus.I_req = 0; bus.I_addr = 0; bus.D_addr = 0; bus.D_wdata = 0;
        bus.D_MREQ = 0; bus.D_IORQ = 0; bus.D_RD = 0; bus.D_WR = 0;
        bus.B_rdata = 0; bus.B_ready = 0;
    endtask

    task automatic tick();
        @(posedge CLK); #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        idle_inputs();
        tick(); tick();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge CLK);
        n_checks++;
        if ({bus.B_addr, bus.B_wdata, bus.B_MREQ, bus.B_IORQ, bus.B_RD, bus.B_WR,
             bus.grant_I, bus.grant_D, bus.err, bus.I_data, bus.D_rdata, bus.I_wait, bus.D_wait} !== 47'h0) begin
            n_errors++;
            $display("FAIL reset_outputs: got addr=%h wd=%h g=%b%b err=%b", bus.B_addr, bus.B_wdata,
                     bus.grant_I, bus.grant_D, bus.err);
        end
        RST = 1'b1; bus.I_req = 1; bus.D_MREQ = 1; bus.D_RD = 1;
        tick();
        @(negedge CLK);
        n_checks++;
        if ({bus.I_wait, bus.D_wait, bus.grant_I, bus.grant_D, bus.B_MREQ} !== 5'b11000) begin
            n_errors++;
            $display("FAIL reset_waits: got Iw=%b Dw=%b gI=%b gD=%b mreq=%b expected 11000",
                     bus.I_wait, bus.D_wait, bus.grant_I, bus.grant_D, bus.B_MREQ);
        end
        do_reset();
    endtask

    task automatic test_d_read();
        do_reset();
        bus.D_MREQ = 1; bus.D_RD = 1; bus.D_addr = 16'h1234; bus.B_ready = 1; bus.B_rdata = 8'h5A;
        @(negedge CLK);
        n_checks++;
        if (bus.D_wait !== 1'b1 || bus.grant_D !== 1'b0) begin
            n_errors++;
            $display("FAIL d_read_cycle1: D_wait=%b grant_D=%b expected 1 0", bus.D_wait, bus.grant_D);
        end
        tick();
        @(negedge CLK);
        n_checks++;
        if ({bus.B_addr, bus.B_MREQ, bus.B_RD, bus.B_IORQ, bus.B_WR, bus.grant_D, bus.D_wait, bus.D_rdata}
            !== {16'h1234, 4'b1100, 1'b1, 1'b0, 8'h5A}) begin
            n_errors++;
            $display("FAIL d_read_complete: addr=%h mreq=%b rd=%b gD=%b Dw=%b rdata=%h expected 1234 1 1 1 0 5a",
                     bus.B_addr, bus.B_MREQ, bus.B_RD, bus.grant_D, bus.D_wait, bus.D_rdata);
        end
        tick();
        idle_inputs();
        @(negedge CLK);
        n_checks++;
        if ({bus.B_MREQ, bus.B_RD, bus.grant_D, bus.B_addr} !== 19'h0) begin
            n_errors++;
            $display("FAIL d_read_idle: mreq=%b rd=%b gD=%b addr=%h expected all 0",
                     bus.B_MREQ, bus.B_RD, bus.grant_D, bus.B_addr);
        end
    endtask

    task automatic test_io_write();
        do_reset();
        bus.D_IORQ = 1; bus.D_WR = 1; bus.D_addr = 16'h00BE; bus.D_wdata = 8'h80; bus.B_rdata = 8'h77;
        tick();
        for (int k = 0; k < 4; k++) begin
            bus.B_ready = (k == 3);
            @(negedge CLK);
            n_checks++;
            if ({bus.B_addr, bus.B_wdata, bus.B_IORQ, bus.B_WR, bus.B_MREQ, bus.B_RD, bus.D_wait, bus.D_rdata}
                !== {16'h00BE, 8'h80, 4'b1100, (k != 3), 8'h00}) begin
                n_errors++;
                $display("FAIL io_write_cyc%0d: addr=%h wd=%h iorq=%b wr=%b Dw=%b rdata=%h", k,
                         bus.B_addr, bus.B_wdata, bus.B_IORQ, bus.B_WR, bus.D_wait, bus.D_rdata);
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_starvation();
        int got[$];
        int exp_who;
        int st;
        do_reset();
        bus.D_MREQ = 1; bus.D_RD = 1; bus.D_addr = 16'h2000;
        bus.I_req = 1; bus.I_addr = 16'h3000; bus.B_ready = 1;
        for (int c = 0; c < 60 && got.size() < 10; c++) begin
            @(negedge CLK);
            if (bus.grant_D === 1'b1) got.push_back(1);
            else if (bus.grant_I === 1'b1) got.push_back(2);
            tick();
        end
        idle_inputs();
        n_checks++;
        if (got.size() != 10) begin
            n_errors++;
            $display("FAIL starve_grant_count: got %0d grants expected 10", got.size());
        end
        st = 0;
        for (int k = 0; k < got.size(); k++) begin
            if (st >= TB_STARVE) begin exp_who = 2; st = 0; end
            else begin exp_who = 1; st = st + 1; end
            n_checks++;
            if (got[k] !== exp_who) begin
                n_errors++;
                $display("FAIL starve_order[%0d]: got %0d expected %0d (1=D 2=I)", k, got[k], exp_who);
            end
        end
    endtask

    task automatic test_timeout();
        int done_at;
        logic [7:0] rd_at;
        do_reset();
        bus.D_MREQ = 1; bus.D_RD = 1; bus.D_addr = 16'h5555; bus.B_rdata = 8'h12;
        tick();
        done_at = -1;
        rd_at = 8'h00;
        for (int k = 1; k <= 80 && done_at < 0; k++) begin
            @(negedge CLK);
            if (bus.D_wait === 1'b0) begin done_at = k; rd_at = bus.D_rdata; end
            tick();
        end
        idle_inputs();
        n_checks++;
        if (done_at != TB_TIMEOUT) begin
            n_errors++;
            $display("FAIL timeout_cycle: completion at %0d expected %0d", done_at, TB_TIMEOUT);
        end
        n_checks++;
        if (rd_at !== 8'hFF) begin
            n_errors++;
            $display("FAIL timeout_rdata: got %h expected ff", rd_at);
        end
        tick(); tick();
        @(negedge CLK);
        n_checks++;
        if (bus.err !== 1'b1 || bus.grant_D !== 1'b0) begin
            n_errors++;
            $display("FAIL timeout_err_sticky: err=%b grant_D=%b expected 1 0", bus.err, bus.grant_D);
        end
        do_reset();
        @(negedge CLK);
        n_checks++;
        if (bus.err !== 1'b0) begin
            n_errors++;
            $display("FAIL timeout_err_clear: err=%b expected 0", bus.err);
        end
    endtask

    task automatic test_invalid();
        do_reset();
        bus.D_MREQ = 1; bus.D_IORQ = 1; bus.D_RD = 1;
        bus.I_req = 1; bus.I_addr = 16'h4000; bus.B_ready = 1; bus.B_rdata = 8'h33;
        @(negedge CLK);
        n_checks++;
        if ({bus.err, bus.D_wait, bus.I_wait} !== 3'b011) begin
            n_errors++;
            $display("FAIL invalid_pre: err=%b Dw=%b Iw=%b expected 0 1 1", bus.err, bus.D_wait, bus.I_wait);
        end
        tick();
        @(negedge CLK);
        n_checks++;
        if ({bus.err, bus.grant_I, bus.grant_D, bus.B_addr, bus.I_wait, bus.I_data, bus.D_wait}
            !== {3'b110, 16'h4000, 1'b0, 8'h33, 1'b1}) begin
            n_errors++;
            $display("FAIL invalid_ifetch: err=%b gI=%b gD=%b addr=%h Iw=%b Idata=%h Dw=%b",
                     bus.err, bus.grant_I, bus.grant_D, bus.B_addr, bus.I_wait, bus.I_data, bus.D_wait);
        end
        tick();
        bus.I_req = 0;
        @(negedge CLK);
        n_checks++;
        if ({bus.err, bus.grant_I, bus.grant_D, bus.D_wait} !== 4'b1001) begin
            n_errors++;
            $display("FAIL invalid_hold: err=%b gI=%b gD=%b Dw=%b expected 1 0 0 1",
                     bus.err, bus.grant_I, bus.grant_D, bus.D_wait);
        end
        idle_inputs();
    endtask

    task automatic test_rst_mid();
        do_reset();
        bus.D_MREQ = 1; bus.D_IORQ = 1; bus.D_WR = 1; bus.I_req = 1; bus.I_addr = 16'h0F0F;
        tick();
        bus.D_MREQ = 0; bus.D_IORQ = 0; bus.D_WR = 0;
        @(negedge CLK);
        n_checks++;
        if ({bus.grant_I, bus.B_MREQ, bus.err} !== 3'b111) begin
            n_errors++;
            $display("FAIL rst_mid_setup: gI=%b mreq=%b err=%b expected 1 1 1", bus.grant_I, bus.B_MREQ, bus.err);
        end
        RST = 1'b1;
        tick();
        RST = 1'b0;
        bus.I_req = 0;
        @(negedge CLK);
        n_checks++;
        if ({bus.grant_I, bus.grant_D, bus.B_MREQ, bus.B_RD, bus.B_addr, bus.err} !== 21'h0) begin
            n_errors++;
            $display("FAIL rst_mid: gI=%b gD=%b mreq=%b rd=%b addr=%h err=%b expected all 0",
                     bus.grant_I, bus.grant_D, bus.B_MREQ, bus.B_RD, bus.B_addr, bus.err);
        end
        idle_inputs();
    endtask

    task automatic test_random();
        logic [48:0] exp_v, got_v;
        logic [7:0]  exp_rd;
        bit in_x, done, timed, d_req, dv, conflict;
        int r;
        do_reset();
        m_owner = 0; m_age = 0; m_starve = 0; m_err = 0;
        m_addr = 0; m_wdata = 0; m_mreq = 0; m_iorq = 0; m_rd = 0; m_wr = 0;
        for (int c = 0; c < 3000; c++) begin
            r = $urandom_range(0, 59);
            bus.D_MREQ = 0; bus.D_IORQ = 0; bus.D_RD = 0; bus.D_WR = 0;
            if (r == 0) begin
                bus.D_MREQ = 1; bus.D_IORQ = 1; bus.D_RD = 1;
            end else if (r < 40) begin
                bus.D_MREQ = ($urandom_range(0, 1) == 1);
                bus.D_IORQ = !bus.D_MREQ;
                bus.D_RD   = ($urandom_range(0, 1) == 1);
                bus.D_WR   = !bus.D_RD;
            end
            bus.D_addr  = 16'($urandom);
            bus.D_wdata = 8'($urandom);
            bus.I_req   = ($urandom_range(0, 2) != 0);
            bus.I_addr  = 16'($urandom);
            bus.B_rdata = 8'($urandom);
            bus.B_ready = (c % 500 > 430) ? 1'b0 : ($urandom_range(0, 3) != 0);
            @(negedge CLK);

            in_x     = (m_owner != 0);
            done     = in_x && (bus.B_ready || m_age == TB_TIMEOUT - 1);
            timed    = done && !bus.B_ready;
            d_req    = bus.D_MREQ || bus.D_IORQ;
            dv       = (int'(bus.D_MREQ) + int'(bus.D_IORQ) == 1) && (int'(bus.D_RD) + int'(bus.D_WR) == 1);
            conflict = d_req && ((bus.D_MREQ && bus.D_IORQ) || (bus.D_RD && bus.D_WR));
            exp_rd   = timed ? 8'hFF : (m_wr ? 8'h00 : bus.B_rdata);
            exp_v = {m_owner == 1, m_owner == 2,
                     in_x ? m_addr : 16'h0, in_x ? m_wdata : 8'h0,
                     in_x && m_mreq, in_x && m_iorq, in_x && m_rd, in_x && m_wr,
                     d_req && !(m_owner == 1 && done), bus.I_req && !(m_owner == 2 && done),
                     (m_owner == 1 && done) ? exp_rd : 8'h0, (m_owner == 2 && done) ? exp_rd : 8'h0,
                     m_err};
            got_v = {bus.grant_D, bus.grant_I, bus.B_addr, bus.B_wdata,
                     bus.B_MREQ, bus.B_IORQ, bus.B_RD, bus.B_WR, bus.D_wait, bus.I_wait,
                     bus.D_rdata, bus.I_data, bus.err};
            n_checks++;
            if (got_v !== exp_v) begin
                n_errors++;
                $display("FAIL random_cycle%0d: got %h expected %h", c, got_v, exp_v);
            end

            m_err = m_err || conflict || timed;
            if (in_x) begin
                if (done) begin m_owner = 0; m_age = 0; end
                else m_age = m_age + 1;
            end else if (dv && !(bus.I_req && m_starve >= TB_STARVE)) begin
                if (bus.I_req) m_starve = (m_starve + 1 > TB_STARVE) ? TB_STARVE : m_starve + 1;
                m_owner = 1; m_age = 0;
                m_addr = bus.D_addr; m_wdata = bus.D_wdata;
                m_mreq = bus.D_MREQ; m_iorq = bus.D_IORQ; m_rd = bus.D_RD; m_wr = bus.D_WR;
            end else if (bus.I_req) begin
                m_starve = 0; m_owner = 2; m_age = 0;
                m_addr = bus.I_addr; m_wdata = 8'h00;
                m_mreq = 1; m_iorq = 0; m_rd = 1; m_wr = 0;
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        RST = 1'b1;
        idle_inputs();
        test_reset();
        test_d_read();
        test_io_write();
        test_starvation();
        test_timeout();
        test_invalid();
        test_rst_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single external memory/IO bus between two requesters: the translator's instruction-fetch port (I-port, memory reads only) and the RISC core MEM-stage data port (D-port, memory/IO reads and writes).
- Sits between risc_core/translator and the board memory/IO decoder, and generates the per-requester active-high wait signals.
- Fixed priority favours the D-port. A starvation counter guarantees that a pending fetch is eventually granted. A bus watchdog prevents the core from hanging on a dead slave.

Parameters:
- STARVE_MAX, 4: number of consecutive lost arbitrations after which a pending I-port request wins over the D-port.
- TIMEOUT, 64: maximum number of cycles in a transfer state without B_ready before the transfer is aborted.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RST  in  1  synchronous reset, active high.
- I_req  in  1  fetch request, level; held until I_wait is low.
- I_addr  in  16  fetch address.
- I_data  out  8  fetch data; valid only in the completion cycle.
- I_wait  out  1  fetch stall, active high.
- D_addr  in  16  core data address.
- D_wdata  in  8  core write data.
- D_MREQ, D_IORQ, D_RD, D_WR  in  1 each  core strobes, active high.
- D_rdata  out  8  read data to the core; valid only in the completion cycle.
- D_wait  out  1  core stall, active high.
- B_addr  out  16  bus address.
- B_wdata  out  8  bus write data.
- B_rdata  in  8  bus read data.
- B_MREQ, B_IORQ, B_RD, B_WR  out  1 each  bus strobes, active high.
- B_ready  in  1  slave completion; sampled only in a transfer state.
- grant_I, grant_D  out  1 each  current owner, one-hot or both zero.
- err  out  1  sticky error flag; cleared only by RST.

Behaviour:
- Reset: RST is synchronous and active high. On reset:
  - state is IDLE and the starvation counter and watchdog are 0;
  - all B_* outputs, grant_*, err, I_data and D_rdata are 0;
  - I_wait and D_wait follow the combinational rules below.
  - RST asserted mid-transfer abandons the transfer; the bus strobes are low after that edge.
- D-port validity:
  - A valid D request is exactly one of MREQ/IORQ together with exactly one of RD/WR.
  - An invalid combination (both MREQ and IORQ, or both RD and WR) is never granted, sets err at the next edge, and keeps D_wait high.
  - No MREQ/IORQ at all means no request.
- States: IDLE, D_XFER, I_XFER.
- IDLE arbitration:
  - Valid D request and I_req with starve_cnt < STARVE_MAX: go to D_XFER.
  - Valid D request and I_req with starve_cnt >= STARVE_MAX: go to I_XFER.
  - Only one of the two requesting: grant that one.
  - Neither: stay in IDLE.
- Grant actions:
  - At the granting edge, latch address, write data and strobe type into the bus output registers, and set the matching grant_*.
  - The I-port drives B_MREQ=1, B_RD=1.
- Transfer states:
  - The bus outputs are held constant.
  - B_ready high in the current cycle is the completion cycle: the requester's wait is low, its data output equals B_rdata on reads (0 on writes), and at the next edge the state returns to IDLE with B_* and grant_* cleared.
  - Minimum latency is 2 cycles from request to completion, plus 1 idle turnaround cycle between back-to-back transfers.
- Wait generation:
  - D_wait = valid-or-invalid D request AND NOT (D_XFER AND completion).
  - I_wait = I_req AND NOT (I_XFER AND completion).
- Withdrawal: a requester that drops its request mid-transfer does not abort it. The transfer completes on the bus and the result is discarded.
- Starvation counter:
  - Increments, saturating at STARVE_MAX, on every IDLE edge where I_req is pending and D wins.
  - Clears when the I-port is granted.
  - Holds its value while I_req is low.
- Watchdog:
  - Counts cycles spent in a transfer state without B_ready.
  - On reaching TIMEOUT-1, that cycle is forced to be a completion cycle: wait goes low, read data is 8'hFF, and err is set.
  - The counter clears on every return to IDLE.
- Arithmetic: the counters saturate and never wrap.

Test Plan:
- D-port read only: D_MREQ=1, D_RD=1, D_addr=16'h1234, B_ready high on the 2nd cycle with B_rdata=8'h5A -> B_addr=16'h1234 and B_MREQ/B_RD=1 from cycle 1; D_wait low and D_rdata=8'h5A on cycle 2; bus idle on cycle 3.
- Simultaneous requests, STARVE_MAX=4, B_ready always high, D requesting continuously -> grant order D,D,D,D,I: the 5th arbitration goes to the I-port and starve_cnt returns to 0.
- IO write D_IORQ=1, D_WR=1, D_addr=16'h00BE, D_wdata=8'h80 -> B_IORQ=1, B_WR=1, B_wdata=8'h80 held until B_ready; D_rdata=0 in the completion cycle.
- B_ready never asserted, TIMEOUT=64 -> completion forced exactly 64 cycles after grant, D_rdata=8'hFF, D_wait low for one cycle, err=1 until RST.
- Invalid D_MREQ=1 with D_IORQ=1 -> no grant, D_wait stays 1, err=1 at the next edge; a concurrent I_req is still served normally.
- RST asserted during an I_XFER with B_ready low -> next edge: state IDLE, B_* and grant_I=0, starve_cnt=0, err=0.
